// File: rtl/otp_ctrl_edn_arb.sv
// Purpose : shares one EDN request/ack port between NumReq entropy consumers.
//           Each grant gathers NumWords EDN words into ReqWidth bits.
// Latency : request sampled in cycle 0, edn_req_o in cycle 1, ack_o in
//           cycle NumWords+1 with zero EDN wait; one idle cycle between grants.
// Backpr. : EDN stalls are absorbed in FetchSt with edn_req_o held high.
//           Requesters hold req_i until acked, and late requests wait for IdleSt.
//
// Ports   : clk_i, rst_i (async, active-high)
//           req_i/ack_o/data_o  - consumer side (ack_o one-hot, one cycle; data_o zero otherwise)
//           edn_req_o/edn_ack_i/edn_data_i - EDN side
//           busy_o (not idle), fsm_err_o (bad state encoding; terminal)
// Config  : OTP_CTRL_EDN_ARB_FIXED_PRIO_EN defined -> fixed priority, where the
//           lowest index wins. Undefined -> round-robin.
module otp_ctrl_edn_arb #(
    parameter int NumReq       = 2,
    parameter int EdnDataWidth = 32,
    parameter int ReqWidth     = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_i,
    output logic [NumReq-1:0]       ack_o,
    output logic [ReqWidth-1:0]     data_o,
    output logic                    edn_req_o,
    input  logic                    edn_ack_i,
    input  logic [EdnDataWidth-1:0] edn_data_i,
    output logic                    busy_o,
    output logic                    fsm_err_o
);

    localparam int NumWords = ReqWidth / EdnDataWidth;
    localparam int CntW     = $clog2(NumWords + 1);
    localparam int IdxW     = $clog2(NumReq);

    // Sparse encoding: every pair of codes differs in 4 bits.
    typedef enum logic [5:0] {
        IdleSt  = 6'b101001,
        FetchSt = 6'b010011,
        AckSt   = 6'b100110,
        ErrorSt = 6'b011100
    } state_e;

    // Plain vectors hold the state so that any 6-bit value, valid or not,
    // can be represented and decoded to ErrorSt.
    logic [5:0]          r_state;
    logic [5:0]          w_state_next;
    logic [IdxW-1:0]     r_gnt_idx;
    logic [CntW-1:0]     r_word_cnt;
    logic [ReqWidth-1:0] r_buf;
    logic [IdxW-1:0]     w_sel_idx;
    logic                w_sel_vld;

`ifdef OTP_CTRL_EDN_ARB_FIXED_PRIO_EN
    // Scan from the top down so that the lowest set index is written last.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = IdxW'(k);
            end
        end
    end
`else
    logic [IdxW-1:0] r_rr_ptr;
    logic [IdxW:0]   w_cand;

    // Search starts at the pointer and wraps. The candidate index is reduced
    // modulo NumReq by one conditional subtract, since ptr+k < 2*NumReq.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NumReq; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (IdxW+1)'(k);
            if (w_cand >= (IdxW+1)'(NumReq)) begin
                w_cand = w_cand - (IdxW+1)'(NumReq);
            end
            if (!w_sel_vld && req_i[w_cand[IdxW-1:0]]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = w_cand[IdxW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (r_state == AckSt) begin
            if (r_gnt_idx == IdxW'(NumReq - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= r_gnt_idx + IdxW'(1);
            end
        end
    end
`endif

    // Next state and all outputs are decoded from registered state only.
    always_comb begin
        w_state_next = r_state;
        edn_req_o    = 1'b0;
        ack_o        = '0;
        data_o       = '0;
        busy_o       = 1'b1;
        fsm_err_o    = 1'b0;
        case (r_state)
            IdleSt: begin
                busy_o = 1'b0;
                if (w_sel_vld) begin
                    w_state_next = FetchSt;
                end
            end
            FetchSt: begin
                edn_req_o = 1'b1;
                if (edn_ack_i && (r_word_cnt == CntW'(NumWords - 1))) begin
                    w_state_next = AckSt;
                end
            end
            AckSt: begin
                ack_o[r_gnt_idx] = 1'b1;
                data_o           = r_buf;
                w_state_next     = IdleSt;
            end
            ErrorSt: begin
                fsm_err_o = 1'b1;
            end
            default: begin
                fsm_err_o    = 1'b1;
                w_state_next = ErrorSt;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IdleSt;
            r_gnt_idx  <= '0;
            r_word_cnt <= '0;
            r_buf      <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IdleSt: begin
                    if (w_sel_vld) begin
                        r_gnt_idx  <= w_sel_idx;
                        r_word_cnt <= '0;
                    end
                end
                FetchSt: begin
                    if (edn_ack_i) begin
                        // Constant slice per word avoids a variable part-select.
                        for (int w = 0; w < NumWords; w++) begin
                            if (r_word_cnt == CntW'(w)) begin
                                r_buf[w*EdnDataWidth +: EdnDataWidth] <= edn_data_i;
                            end
                        end
                        r_word_cnt <= r_word_cnt + CntW'(1);
                    end
                end
                AckSt: begin
                    r_buf <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
